// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csr_pkg
//  Purpose  : Shared types and constants for the diagonal CSR generator.
//             - Default index width and packed-bus depth.
//             - State encoding for the generator FSM.
//             - Stream selector values.
//             - Packed-slice base helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package csr_pkg;

  // Default width of one index/offset entry and number of entries per bus
  localparam int CSR_WIDTH = 10;
  localparam int CSR_SIZE  = 1024;

  // Generator FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OFFS = 2'd1,
    COLS = 2'd2,
    FIN  = 2'd3
  } csr_state_e;

  // out_sel encoding: which CSR array the current stream entry belongs to
  localparam logic SEL_OFFS = 1'b0;
  localparam logic SEL_COLS = 1'b1;

  // Low bit position of entry idx inside a packed bus of w-bit entries
  function automatic int unsigned csr_slice_lo(input int unsigned idx,
                                               input int unsigned w);
    return idx * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_pack_wr.sv
`default_nettype none
// ============================================================================
//  Module   : csr_pack_wr
//  Purpose  : Holds one WIDTH*SIZE packed array. A write strobe stores one
//             WIDTH-bit entry at index i_addr; a clear strobe zeroes the
//             whole bus (clear wins over write).
//  Ports    : clk, rst       - clock, asynchronous active-high reset
//             i_clr          - clear the entire bus
//             i_we           - write i_data to entry i_addr
//             i_addr, i_data - entry index and value
//             o_bus          - packed array, entry k at [k*WIDTH +: WIDTH]
//  Revision : 1.0  initial release
// ============================================================================
module csr_pack_wr
  import csr_pkg::*;
#(
  parameter int WIDTH = CSR_WIDTH,
  parameter int SIZE  = CSR_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [WIDTH-1:0]      i_addr,
  input  logic [WIDTH-1:0]      i_data,
  output logic [WIDTH*SIZE-1:0] o_bus
);

  localparam int c_AW = $clog2(WIDTH * SIZE);

  logic [WIDTH*SIZE-1:0] r_bus;
  logic [c_AW-1:0]       w_base;
  logic                  w_in_range;

  assign w_base     = c_AW'(csr_slice_lo(32'(i_addr), WIDTH));
  // With WIDTH wider than log2(SIZE) an index could point past the bus
  assign w_in_range = (32'(i_addr) < 32'(SIZE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus <= '0;
    end else if (i_clr) begin
      r_bus <= '0;
    end else if (i_we && w_in_range) begin
      r_bus[w_base +: WIDTH] <= i_data;
    end
  end

  assign o_bus = r_bus;

endmodule
`default_nettype wire

// File: rtl/csr_diag_gen.sv
`default_nettype none
// ============================================================================
//  Module   : csr_diag_gen
//  Purpose  : Generator for identity / shifted-diagonal CSR matrices.
//             Streams num_row+1 row offsets (0..num_row) followed by num_row
//             column indices (i + diag_off, modulo 2^WIDTH) on a valid/ready
//             stream, and mirrors every accepted entry into packed buses laid
//             out the way the diagonal verifier reads them.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             start               - job request, sampled only when idle
//             num_row, diag_off   - job parameters, latched on accepted start
//             out_valid/out_ready - stream handshake
//             out_data, out_sel, out_idx, out_last - stream entry payload
//             offsets, colIdx     - packed CSR arrays
//             nnz                 - latched num_row, valid with done
//             busy, done, err     - job status levels
//  Options  : CSR_DIAG_GEN_FAULT_EN adds fault_en / fault_idx inputs that
//             bump one column index by +1 for verifier negative tests.
//  Revision : 1.0  initial release
// ============================================================================
module csr_diag_gen
  import csr_pkg::*;
#(
  parameter int WIDTH = CSR_WIDTH,
  parameter int SIZE  = CSR_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      num_row,
  input  logic [WIDTH-1:0]      diag_off,
`ifdef CSR_DIAG_GEN_FAULT_EN
  input  logic                  fault_en,
  input  logic [WIDTH-1:0]      fault_idx,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sel,
  output logic [WIDTH-1:0]      out_idx,
  output logic                  out_last,
  output logic [WIDTH*SIZE-1:0] offsets,
  output logic [WIDTH*SIZE-1:0] colIdx,
  output logic [WIDTH-1:0]      nnz,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // --------------------------------------------------------------------------
  // State and job registers
  // --------------------------------------------------------------------------
  csr_state_e       r_state;
  csr_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_idx;
  logic [WIDTH-1:0] r_num_row;
  logic [WIDTH-1:0] r_diag_off;
  logic [WIDTH-1:0] r_nnz;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_hs;
  logic             w_start_seen;
  logic             w_too_big;
  logic             w_start_ok;
  logic             w_offs_end;
  logic             w_cols_end;
  logic             w_fault_hit;
  logic [WIDTH-1:0] w_col_val;

  // A start is only looked at while idle; an oversize request is rejected
  assign w_start_seen = (r_state == IDLE) && start;
  assign w_too_big    = (32'(num_row) > 32'(SIZE - 1));
  assign w_start_ok   = w_start_seen && !w_too_big;

  assign w_hs       = out_valid && out_ready;
  assign w_offs_end = (r_idx == r_num_row);
  assign w_cols_end = (r_idx == (r_num_row - WIDTH'(1)));

`ifdef CSR_DIAG_GEN_FAULT_EN
  logic             r_fault_en;
  logic [WIDTH-1:0] r_fault_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault_en  <= 1'b0;
      r_fault_idx <= '0;
    end else if (w_start_ok) begin
      r_fault_en  <= fault_en;
      r_fault_idx <= fault_idx;
    end
  end

  // Column entries only run to num_row-1, so a fault_idx at or beyond
  // num_row never matches and the output stays clean.
  assign w_fault_hit = r_fault_en && (r_fault_idx == r_idx);
`else
  assign w_fault_hit = 1'b0;
`endif

  // Wraps silently past 2^WIDTH; the verifier is expected to catch the
  // resulting non-unit step.
  assign w_col_val = r_idx + r_diag_off + WIDTH'(w_fault_hit);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = OFFS;
        end
      end
      OFFS: begin
        if (w_hs && w_offs_end) begin
          // A zero-row matrix has no column entries at all
          w_state_nxt = (r_num_row == '0) ? FIN : COLS;
        end
      end
      COLS: begin
        if (w_hs && w_cols_end) begin
          w_state_nxt = FIN;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: stream outputs (Moore; payload depends only on state and r_idx,
  // so it is naturally stable while the consumer stalls)
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    out_sel   = SEL_OFFS;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    case (r_state)
      OFFS: begin
        out_valid = 1'b1;
        out_sel   = SEL_OFFS;
        out_data  = r_idx;
        out_idx   = r_idx;
        out_last  = (r_num_row == '0);
      end
      COLS: begin
        out_valid = 1'b1;
        out_sel   = SEL_COLS;
        out_data  = w_col_val;
        out_idx   = r_idx;
        out_last  = w_cols_end;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Job datapath: index counter, latched parameters, status levels
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_num_row  <= '0;
      r_diag_off <= '0;
      r_nnz      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_seen) begin
            r_done <= 1'b0;
            r_err  <= w_too_big;
            if (!w_too_big) begin
              r_num_row  <= num_row;
              r_diag_off <= diag_off;
              r_idx      <= '0;
              r_busy     <= 1'b1;
            end
          end
        end
        OFFS: begin
          if (w_hs) begin
            if (w_offs_end) begin
              r_idx <= '0;
              if (r_num_row == '0) begin
                r_busy <= 1'b0;
              end
            end else begin
              r_idx <= r_idx + WIDTH'(1);
            end
          end
        end
        COLS: begin
          if (w_hs) begin
            r_idx <= r_idx + WIDTH'(1);
            if (w_cols_end) begin
              r_busy <= 1'b0;
            end
          end
        end
        FIN: begin
          r_done <= 1'b1;
          r_nnz  <= r_num_row;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign nnz  = r_nnz;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

  // --------------------------------------------------------------------------
  // Packed CSR arrays, written only on accepted stream entries
  // --------------------------------------------------------------------------
  csr_pack_wr #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_offs_wr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start_ok),
    .i_we   (w_hs && (r_state == OFFS)),
    .i_addr (r_idx),
    .i_data (out_data),
    .o_bus  (offsets)
  );

  csr_pack_wr #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_cols_wr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start_ok),
    .i_we   (w_hs && (r_state == COLS)),
    .i_addr (r_idx),
    .i_data (out_data),
    .o_bus  (colIdx)
  );

endmodule
`default_nettype wire

// File: tb/tb_csr_diag_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_diag_gen
//  Purpose  : Directed self-checking bench for csr_diag_gen. Drives inputs
//             and samples outputs on the falling clock edge. A second
//             instance with WIDTH=11 exercises the oversize-request path.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csr_diag_gen;
  import csr_pkg::*;

  localparam int W   = 10;
  localparam int S   = 1024;
  localparam int W11 = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (WIDTH=10)
  logic           start = 1'b0;
  logic [W-1:0]   num_row = '0;
  logic [W-1:0]   diag_off = '0;
  logic           out_ready = 1'b1;
  logic           out_valid, out_sel, out_last, busy, done, err;
  logic [W-1:0]   out_data, out_idx, nnz;
  logic [W*S-1:0] offsets, colIdx;
`ifdef CSR_DIAG_GEN_FAULT_EN
  logic           fault_en = 1'b0;
  logic [W-1:0]   fault_idx = '0;
  logic [W11-1:0] s_fault_idx = '0;
`endif

  // Wide instance (WIDTH=11) so that num_row=1024 is representable
  logic             s_start = 1'b0;
  logic [W11-1:0]   s_num = '0;
  logic [W11-1:0]   s_doff = '0;
  logic             s_ready = 1'b1;
  logic             s_valid, s_sel, s_last, s_busy, s_done, s_err;
  logic [W11-1:0]   s_data, s_idx, s_nnz;
  logic [W11*S-1:0] s_offs, s_cols;

  csr_diag_gen #(.WIDTH(W), .SIZE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .num_row(num_row), .diag_off(diag_off),
`ifdef CSR_DIAG_GEN_FAULT_EN
    .fault_en(fault_en), .fault_idx(fault_idx),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_idx(out_idx), .out_last(out_last),
    .offsets(offsets), .colIdx(colIdx), .nnz(nnz),
    .busy(busy), .done(done), .err(err)
  );

  csr_diag_gen #(.WIDTH(W11), .SIZE(S)) dut11 (
    .clk(clk), .rst(rst), .start(s_start), .num_row(s_num), .diag_off(s_doff),
`ifdef CSR_DIAG_GEN_FAULT_EN
    .fault_en(1'b0), .fault_idx(s_fault_idx),
`endif
    .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data),
    .out_sel(s_sel), .out_idx(s_idx), .out_last(s_last),
    .offsets(s_offs), .colIdx(s_cols), .nnz(s_nnz),
    .busy(s_busy), .done(s_done), .err(s_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int m_fault_en  = 0;
  int m_fault_idx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] off_at(input int i);
    logic [13:0] b;
    b = 14'(i * W);
    return 64'(offsets[b +: W]);
  endfunction

  function automatic logic [63:0] col_at(input int i);
    logic [13:0] b;
    b = 14'(i * W);
    return 64'(colIdx[b +: W]);
  endfunction

  function automatic logic [63:0] scol_at(input int i);
    logic [13:0] b;
    b = 14'(i * W11);
    return 64'(s_cols[b +: W11]);
  endfunction

  // Expected k-th stream entry: offsets 0..n, then columns j+doff for j<n
  task automatic exp_entry(input int n, input int doff, input int k,
                           output logic [W-1:0] e_data, output logic e_sel,
                           output logic [W-1:0] e_idx, output logic e_last);
    int j;
    if (k <= n) begin
      e_sel  = 1'b0;
      e_idx  = W'(k);
      e_data = W'(k);
      e_last = (n == 0);
    end else begin
      j      = k - n - 1;
      e_sel  = 1'b1;
      e_idx  = W'(j);
      e_data = W'(j + doff + (((m_fault_en != 0) && (j == m_fault_idx)) ? 1 : 0));
      e_last = (j == n - 1);
    end
  endtask

  // Runs one job on the main instance. done_cyc is the cycle index where
  // done is first seen, with the start-sampling cycle counted as cycle 0.
  task automatic run_job(input string tag, input int n, input int doff,
                         input bit stall, output int done_cyc);
    int k, total, cyc;
    logic [W-1:0] ed, ei;
    logic es, el;
    total = 2 * n + 1;
    k     = 0;
    @(negedge clk);
    start     = 1'b1;
    num_row   = W'(n);
    diag_off  = W'(doff);
    out_ready = 1'b1;
`ifdef CSR_DIAG_GEN_FAULT_EN
    fault_en  = (m_fault_en != 0);
    fault_idx = W'(m_fault_idx);
`endif
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    chk({tag, "_busy_run"}, 64'(busy), 64'd1);
    while (!done && cyc < 4 * total + 20) begin
      out_ready = stall ? ((cyc % 3) == 1) : 1'b1;
      chk({tag, "_valid"}, 64'(out_valid), 64'(k < total));
      if (out_valid && k < total) begin
        exp_entry(n, doff, k, ed, es, ei, el);
        chk({tag, "_data"}, 64'(out_data), 64'(ed));
        chk({tag, "_sel"},  64'(out_sel),  64'(es));
        chk({tag, "_idx"},  64'(out_idx),  64'(ei));
        chk({tag, "_last"}, 64'(out_last), 64'(el));
      end
      if (out_valid && out_ready) k++;
      @(negedge clk);
      cyc++;
    end
    done_cyc = cyc;
    chk({tag, "_done"},   64'(done), 64'd1);
    chk({tag, "_count"},  64'(k),    64'(total));
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_nnz"},    64'(nnz),  64'(n));
    out_ready = 1'b1;
  endtask

  initial begin
    int dc, cyc, hs;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_err",   64'(err),       64'd0);
    chk("rst_nnz",   64'(nnz),       64'd0);
    chk("rst_buses", 64'((offsets == '0) && (colIdx == '0)), 64'd1);
    rst = 1'b0;

    // ---------------- identity, 4 rows, full throughput ----------------
    run_job("n4", 4, 0, 1'b0, dc);
    chk("n4_done_cyc", 64'(dc), 64'd11);
    for (int i = 0; i <= 4; i++) chk("n4_offs_bus", off_at(i), 64'(i));
    for (int i = 0; i < 4; i++)  chk("n4_cols_bus", col_at(i), 64'(i));
    chk("n4_offs_tail", off_at(5), 64'd0);
    chk("n4_cols_tail", col_at(4), 64'd0);

    // ---------------- zero rows: buses cleared, single entry ----------------
    run_job("n0", 0, 0, 1'b0, dc);
    chk("n0_done_cyc", 64'(dc), 64'd3);
    chk("n0_offs_zero", 64'(offsets == '0), 64'd1);
    chk("n0_cols_zero", 64'(colIdx == '0), 64'd1);

    // ---------------- 3 rows, shift 2, ready pattern 1,0,0 ----------------
    run_job("stall", 3, 2, 1'b1, dc);
    chk("stall_col0", col_at(0), 64'd2);
    chk("stall_col2", col_at(2), 64'd4);
    chk("stall_off3", off_at(3), 64'd3);

    // ---------------- async reset in the middle of COLS ----------------
    @(negedge clk);
    start = 1'b1; num_row = W'(10); diag_off = W'(0);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_sel) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reached_cols", 64'(out_valid && out_sel), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_stat",  64'({busy, done, err, out_last, out_sel}), 64'd0);
    chk("mid_rst_data",  64'({out_data, out_idx, nnz}), 64'd0);
    chk("mid_rst_buses", 64'((offsets == '0) && (colIdx == '0)), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_post_valid", 64'(out_valid), 64'd0);

    // ---------------- max rows, shift 2: last column wraps to 0 ----------------
    run_job("n1023", 1023, 2, 1'b0, dc);
    chk("n1023_done_cyc", 64'(dc), 64'd2049);
    chk("n1023_col0",    col_at(0),    64'd2);
    chk("n1023_col1021", col_at(1021), 64'd1023);
    chk("n1023_col1022", col_at(1022), 64'd0);
    chk("n1023_col1023", col_at(1023), 64'd0);
    chk("n1023_off1023", off_at(1023), 64'd1023);

    // ---------------- WIDTH=11: oversize request rejected ----------------
    @(negedge clk);
    s_start = 1'b1; s_num = 11'd1024; s_doff = '0;
    @(negedge clk);
    s_start = 1'b0;
    chk("big_err",  64'(s_err),  64'd1);
    chk("big_busy", 64'(s_busy), 64'd0);
    hs = 0;
    for (int i = 0; i < 4; i++) begin
      if (s_valid) hs++;
      @(negedge clk);
    end
    chk("big_no_valid", 64'(hs), 64'd0);

    // accepted job (2 rows, shift 5) with a stray start while busy
    s_start = 1'b1; s_num = 11'd2; s_doff = 11'd5;
    @(negedge clk);
    s_start = 1'b0;
    chk("w11_err_clr", 64'(s_err), 64'd0);
    cyc = 1; hs = 0;
    while (!s_done && cyc < 50) begin
      if (cyc == 2) begin
        s_start = 1'b1; s_num = 11'd7;
      end else begin
        s_start = 1'b0;
      end
      if (s_valid) hs++;
      @(negedge clk);
      cyc++;
    end
    s_start = 1'b0;
    chk("w11_done_cyc", 64'(cyc), 64'd7);
    chk("w11_entries",  64'(hs),  64'd5);
    chk("w11_nnz",      64'(s_nnz), 64'd2);
    chk("w11_col0", scol_at(0), 64'd5);
    chk("w11_col1", scol_at(1), 64'd6);
    chk("w11_col2", scol_at(2), 64'd0);
    repeat (2) @(negedge clk);
    chk("w11_stray_ignored", 64'(s_busy), 64'd0);

`ifdef CSR_DIAG_GEN_FAULT_EN
    // ---------------- injected fault: column 2 bumped by one ----------------
    m_fault_en  = 1;
    m_fault_idx = 2;
    run_job("fault", 5, 0, 1'b0, dc);
    chk("fault_col2", col_at(2), 64'd3);
    chk("fault_col3", col_at(3), 64'd3);
    m_fault_en  = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
